// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Also carries the RISC-V defaults: XLEN default, canonical NOP encoding and PC step.
package fetch_unit_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  // Width needed to hold a count of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer holding {pc, data, fault}.
// Provides a synchronous flush and an occupancy count.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [31:0]     push_data,
  input  logic            push_fault,
  input  logic            pop,
  output logic            head_valid,
  output logic [XLEN-1:0] head_pc,
  output logic [31:0]     head_data,
  output logic            head_fault,
  output logic [CW-1:0]   count
);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     data_mem  [DEPTH];
  logic            fault_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, do_push, do_pop;

  assign full       = (count == CW'(DEPTH));
  assign head_valid = (count != '0);
  assign do_push    = push && !full && !flush;
  assign do_pop     = pop && head_valid && !flush;

  // Head is gated so an empty buffer presents zeros rather than stale entries.
  assign head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;
  assign head_data  = head_valid ? data_mem[rd_ptr]  : '0;
  assign head_fault = head_valid ? fault_mem[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]    <= push_pc;
      data_mem[wr_ptr]  <= push_data;
      fault_mem[wr_ptr] <= push_fault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, credit-limited imem requests, in-order buffering, redirect flush.
// Optional misaligned-redirect trap enabled by defining MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc,
`ifdef MISALIGN_TRAP_EN
  output logic            instr_fault,
`endif
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int              CW      = cnt_width(FIFO_DEPTH);
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);

  logic [XLEN-1:0] fetch_pc, rsp_pc, redir_tgt;
  logic [CW-1:0]   inflight, inflight_d, drop_cnt, fifo_count;
  logic            started, accept, rsp_keep, fault_push;
  logic            push, pop, head_valid, head_fault;
  logic [31:0]     push_data;
  fetch_state_e    state, state_d;

`ifdef MISALIGN_TRAP_EN
  logic fault_pushed;
  assign redir_tgt   = redirect_pc;
  assign instr_fault = head_fault;
`else
  assign redir_tgt   = redirect_pc & ~XLEN'(3);
`endif

  // Credit counts dropped-but-outstanding responses too, so every response always has a slot.
  assign imem_req_valid = started && (state == ST_RUN) && !redirect_valid &&
                          (({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign inflight_d     = inflight + CW'(accept) - CW'(imem_rsp_valid);
  assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

  assign push      = rsp_keep || fault_push;
  assign push_data = fault_push ? INSTR_NOP : imem_rsp_data;
  assign pop       = instr_ready && head_valid && !head_fault && !redirect_valid;

  always_comb begin
    state_d    = state;
    fault_push = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (redirect_valid)
      state_d = (redirect_pc[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
    fault_push = (state == ST_FAULT) && (drop_cnt == '0) && !fault_pushed && !redirect_valid;
`else
    state_d = ST_RUN;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_d;
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fault_pushed <= 1'b0;
    else if (redirect_valid) fault_pushed <= 1'b0;
    else if (fault_push)     fault_pushed <= 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      started  <= 1'b0;
    end else begin
      started  <= 1'b1;
      inflight <= inflight_d;
      if (redirect_valid) begin
        fetch_pc <= redir_tgt;
        rsp_pc   <= redir_tgt;
        // Everything still outstanding predates the redirect; earlier pending drops are a subset of it.
        drop_cnt <= inflight_d;
      end else begin
        if (accept)   fetch_pc <= fetch_pc + STEP;
        if (rsp_keep) rsp_pc   <= rsp_pc + STEP;
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_pc    (rsp_pc),
    .push_data  (push_data),
    .push_fault (fault_push),
    .pop        (pop),
    .head_valid (head_valid),
    .head_pc    (instr_pc),
    .head_data  (instr_data),
    .head_fault (head_fault),
    .count      (fifo_count)
  );

  assign instr_valid = head_valid;

endmodule
